pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Pipeline sequencing controller for the 5-stage RISC-V core. It drives the write-enable, flush and bubble controls of the PC, IF/ID, ID/EX and EX/MEM pipeline registers. It resolves three cases: load-use hazards, multi-cycle EX operations (mul/div) and taken-branch flushes. It also keeps a saturating stall-cycle performance counter.

Parameters:
MC_CYCLES, 4, total EX occupancy in cycles of a multi-cycle op (legal range 2..16)
CNT_W, 16, width of stall_cycles counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
id_rs1  input  5  rs1 index of instruction in ID
id_rs2  input  5  rs2 index of instruction in ID
id_uses_rs1  input  1  ID instruction reads rs1
id_uses_rs2  input  1  ID instruction reads rs2
ex_rd  input  5  destination index of instruction in EX
ex_mem_read  input  1  EX instruction is a load
ex_multicycle  input  1  EX instruction is a multi-cycle op, valid on first EX cycle
ex_branch_taken  input  1  EX resolved a taken branch/jump this cycle
pc_write_en  output  1  PC register update enable
if_id_write_en  output  1  IF/ID register load enable
if_id_flush  output  1  IF/ID loads NOP
id_ex_bubble  output  1  ID/EX loads zero controls (write=0, alu_operation=0)
ex_hold  output  1  ID/EX keeps current contents
ex_mem_bubble  output  1  EX/MEM loads zero controls
mc_busy  output  1  multi-cycle op in progress
mc_done  output  1  one-cycle pulse on final multi-cycle cycle
stall_cycles  output  CNT_W  count of cycles with pc_write_en=0

Behaviour:
- Reset is asynchronous and active-low: reset=0 -> state=RUN, mc counter=0, stall_cycles=0.
- Output values while reset=0: pc_write_en=0, if_id_write_en=0, if_id_flush=1, id_ex_bubble=1, ex_hold=0, ex_mem_bubble=1, mc_busy=0, mc_done=0.
- States: RUN, MC_BUSY. Controls are combinational from state and inputs, so there is zero-latency stall.
- Default outputs in RUN with no event: pc_write_en=1, if_id_write_en=1, all flush/bubble/hold signals=0.
- Event priority in RUN, highest first: branch > multicycle > load-use.
- Branch (ex_branch_taken=1):
  - if_id_flush=1, id_ex_bubble=1, pc_write_en=1, if_id_write_en=1.
  - ex_multicycle is ignored that cycle.
  - A coincident load-use is suppressed because the ID instruction is killed.
- Multicycle (ex_multicycle=1, no branch):
  - This cycle: pc_write_en=0, if_id_write_en=0, ex_hold=1, ex_mem_bubble=1.
  - Load counter with MC_CYCLES-2 and go to MC_BUSY.
- Load-use:
  - Hazard = ex_mem_read & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
  - On hazard: pc_write_en=0, if_id_write_en=0, id_ex_bubble=1.
  - The stall lasts exactly 1 cycle, because the load leaves EX on the next edge.
- MC_BUSY:
  - mc_busy=1, pc_write_en=0, if_id_write_en=0, ex_hold=1, ex_mem_bubble=1.
  - All inputs are ignored, including branch and load-use.
  - Counter decrements each cycle.
  - When counter==0: ex_hold=0, ex_mem_bubble=0, mc_done=1, and next state is RUN. The result enters EX/MEM and ID/EX accepts the held instruction's successor.
  - pc_write_en and if_id_write_en stay 0 on the mc_done cycle and are released the cycle after.
  - Total front-end stall = MC_CYCLES cycles per multi-cycle op.
- Back-to-back multicycle: ex_multicycle is sampled only in RUN. A new op appearing in EX the cycle after mc_done starts a fresh sequence.
- stall_cycles: +1 on every rising edge where pc_write_en=0 and reset=1. It saturates at 2^CNT_W-1 and does not wrap.
- Reset mid-MC_BUSY aborts immediately: RUN, counter=0, mc_done not pulsed.
- ex_mem_read and ex_multicycle both 1 is illegal; multicycle wins.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 -> exactly 1 cycle with pc_write_en=0, if_id_write_en=0, id_ex_bubble=1; stall_cycles 0->1.
- Load to x0 / no use: ex_rd=0 with id_rs1=0, then ex_rd=7 with id_uses_rs1=0 and id_rs1=7 -> no stall, pc_write_en stays 1.
- Multicycle with MC_CYCLES=4: ex_multicycle pulse -> pc_write_en=0 for 4 cycles, mc_busy high for 3, ex_hold high for 3, mc_done on the 4th, stall_cycles=4.
- Branch plus load-use same cycle -> if_id_flush=1, id_ex_bubble=1, pc_write_en=1, no stall; branch plus ex_multicycle same cycle -> no MC_BUSY entry.
- Reset (reset=0) asserted on the 2nd MC_BUSY cycle -> outputs immediately take reset values, mc_done never pulses; after release, state is RUN with pc_write_en=1.
- Saturation with CNT_W=4 -> 20 multicycle stall cycles leave stall_cycles=15.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Purpose: pipeline sequencing for a 5-stage core (load-use stall, multi-cycle EX hold, branch flush, stall counter).
// Latency: all controls are combinational from state and inputs, so stalls and flushes take effect in the same cycle.
// Backpressure: freezes PC and IF/ID (pc_write_en/if_id_write_en low) for 1 cycle on load-use and MC_CYCLES cycles on mul/div.
//
// Ports:
//   clk, reset (async, active-low)
//   id_rs1/id_rs2/id_uses_rs1/id_uses_rs2 : source operands of the ID instruction
//   ex_rd/ex_mem_read/ex_multicycle/ex_branch_taken : status of the EX instruction
//   pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble, ex_hold, ex_mem_bubble : pipeline register controls
//   mc_busy, mc_done : multi-cycle op status
//   stall_cycles : saturating count of cycles with pc_write_en low
module pipe_hazard_ctrl #(
    parameter int MC_CYCLES = 4,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_multicycle,
    input  logic             ex_branch_taken,
    output logic             pc_write_en,
    output logic             if_id_write_en,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             ex_hold,
    output logic             ex_mem_bubble,
    output logic             mc_busy,
    output logic             mc_done,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_MC_BUSY = 1'b1
    } state_t;

    // The first EX cycle of a multi-cycle op is spent in RUN and the last
    // one is the counter==0 cycle, so the counter starts at MC_CYCLES-2.
    localparam logic [3:0]       MC_LOAD = 4'(MC_CYCLES - 2);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t     state;
    logic [3:0] mc_cnt;
    logic       load_use;

    assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                       (id_uses_rs2 && (id_rs2 == ex_rd)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_RUN;
            mc_cnt <= 4'd0;
        end else begin
            case (state)
                ST_RUN: begin
                    // A taken branch kills whatever sits in EX's shadow, so a
                    // coincident multi-cycle request is dropped.
                    if (!ex_branch_taken && ex_multicycle) begin
                        state  <= ST_MC_BUSY;
                        mc_cnt <= MC_LOAD;
                    end
                end
                ST_MC_BUSY: begin
                    if (mc_cnt == 4'd0) begin
                        state <= ST_RUN;
                    end else begin
                        mc_cnt <= mc_cnt - 4'd1;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles <= '0;
        end else if (!pc_write_en && (stall_cycles != CNT_MAX)) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

    always_comb begin
        pc_write_en    = 1'b1;
        if_id_write_en = 1'b1;
        if_id_flush    = 1'b0;
        id_ex_bubble   = 1'b0;
        ex_hold        = 1'b0;
        ex_mem_bubble  = 1'b0;
        mc_busy        = 1'b0;
        mc_done        = 1'b0;
        if (!reset) begin
            // Pipeline held empty while in reset.
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            if_id_flush    = 1'b1;
            id_ex_bubble   = 1'b1;
            ex_mem_bubble  = 1'b1;
        end else if (state == ST_MC_BUSY) begin
            mc_busy        = 1'b1;
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            if (mc_cnt == 4'd0) begin
                // Result drops into EX/MEM; front end is released next cycle.
                mc_done = 1'b1;
            end else begin
                ex_hold       = 1'b1;
                ex_mem_bubble = 1'b1;
            end
        end else if (ex_branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (ex_multicycle) begin
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            ex_hold        = 1'b1;
            ex_mem_bubble  = 1'b1;
        end else if (load_use) begin
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            id_ex_bubble   = 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Purpose: self-checking bench for pipe_hazard_ctrl (table vectors, corner sequences, random vs. model).
// Latency: checks combinational controls mid-cycle and counters 1 time unit after each rising edge.
// Backpressure: n/a (bench drives every input every cycle).
module tb_pipe_hazard_ctrl;

    localparam int MC = 4;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       u1;
        logic       u2;
        logic       mr;
        logic       mc;
        logic       br;
    } in_t;

    // MSB first: pc, ifid, flush, bubble, hold, mem_bubble, busy, done
    typedef struct packed {
        logic pc;
        logic ifid;
        logic flush;
        logic bub;
        logic hold;
        logic memb;
        logic busy;
        logic done;
    } out_t;

    typedef struct {
        in_t  i;
        out_t e;
    } vec_t;

    localparam out_t O_IDLE  = 8'b1100_0000;
    localparam out_t O_LU    = 8'b0001_0000;
    localparam out_t O_BR    = 8'b1111_0000;
    localparam out_t O_RESET = 8'b0011_0100;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_uses_rs1, id_uses_rs2, ex_mem_read, ex_multicycle, ex_branch_taken;

    logic pc_a, ifid_a, flush_a, bub_a, hold_a, memb_a, busy_a, done_a;
    logic pc_b, ifid_b, flush_b, bub_b, hold_b, memb_b, busy_b, done_b;
    logic [15:0] stall_a;
    logic [3:0]  stall_b;
    out_t act_a, act_b;

    assign act_a = {pc_a, ifid_a, flush_a, bub_a, hold_a, memb_a, busy_a, done_a};
    assign act_b = {pc_b, ifid_b, flush_b, bub_b, hold_b, memb_b, busy_b, done_b};

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MC_CYCLES(MC), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_multicycle(ex_multicycle),
        .ex_branch_taken(ex_branch_taken),
        .pc_write_en(pc_a), .if_id_write_en(ifid_a), .if_id_flush(flush_a), .id_ex_bubble(bub_a),
        .ex_hold(hold_a), .ex_mem_bubble(memb_a), .mc_busy(busy_a), .mc_done(done_a),
        .stall_cycles(stall_a)
    );

    pipe_hazard_ctrl #(.MC_CYCLES(MC), .CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_multicycle(ex_multicycle),
        .ex_branch_taken(ex_branch_taken),
        .pc_write_en(pc_b), .if_id_write_en(ifid_b), .if_id_flush(flush_b), .id_ex_bubble(bub_b),
        .ex_hold(hold_b), .ex_mem_bubble(memb_b), .mc_busy(busy_b), .mc_done(done_b),
        .stall_cycles(stall_b)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: cycles of the current multi-cycle op still to come
    // (including the done cycle), plus the two expected counter values.
    int busy_left = 0;
    int cnt16     = 0;
    int cnt4      = 0;
    out_t last_out;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic in_t mk(input int rs1, input int rs2, input int rd,
                               input bit u1, input bit u2, input bit mr, input bit mc, input bit br);
        in_t v;
        v.rs1 = 5'(rs1);
        v.rs2 = 5'(rs2);
        v.rd  = 5'(rd);
        v.u1  = u1;
        v.u2  = u2;
        v.mr  = mr;
        v.mc  = mc;
        v.br  = br;
        return v;
    endfunction

    function automatic out_t model_out(input in_t v);
        bit   hazard;
        out_t o;
        hazard = v.mr && (v.rd != 0) &&
                 ((v.u1 && v.rs1 == v.rd) || (v.u2 && v.rs2 == v.rd));
        if (!reset)                o = O_RESET;
        else if (busy_left == 1)   o = 8'b0000_0011;
        else if (busy_left > 1)    o = 8'b0000_1110;
        else if (v.br)             o = O_BR;
        else if (v.mc)             o = 8'b0000_1100;
        else if (hazard)           o = O_LU;
        else                       o = O_IDLE;
        return o;
    endfunction

    task automatic drive(input in_t v);
        id_rs1          = v.rs1;
        id_rs2          = v.rs2;
        ex_rd           = v.rd;
        id_uses_rs1     = v.u1;
        id_uses_rs2     = v.u2;
        ex_mem_read     = v.mr;
        ex_multicycle   = v.mc;
        ex_branch_taken = v.br;
    endtask

    // Entered at posedge+1; leaves at the next posedge+1.
    task automatic step(input in_t v);
        out_t e;
        drive(v);
        #3;
        e = model_out(v);
        chk("outs", 32'(act_a), 32'(e));
        chk("outs_sat", 32'(act_b), 32'(e));
        last_out = act_a;
        @(posedge clk);
        if (reset) begin
            if (busy_left > 0)       busy_left--;
            else if (!v.br && v.mc)  busy_left = MC - 1;
            if (!e.pc) begin
                if (cnt16 < 65535) cnt16++;
                if (cnt4 < 15)     cnt4++;
            end
        end
        #1;
        chk("stall_cycles", 32'(stall_a), 32'(cnt16));
        chk("stall_cycles_sat", 32'(stall_b), 32'(cnt4));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
        busy_left = 0;
        cnt16     = 0;
        cnt4      = 0;
        #1;
        chk("reset_outs", 32'(act_a), 32'(O_RESET));
        chk("reset_stall", 32'(stall_a), 32'd0);
        @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[9];
    in_t  idle, v;
    int   pc_low, busy_n, hold_n, done_at;

    initial begin
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0);
        tbl[0].i = mk(1, 2, 3, 1, 1, 1, 0, 0); tbl[0].e = O_IDLE;  // load, no dependence
        tbl[1].i = mk(1, 5, 5, 1, 1, 1, 0, 0); tbl[1].e = O_LU;    // load-use on rs2
        tbl[2].i = mk(9, 4, 9, 1, 0, 1, 0, 0); tbl[2].e = O_LU;    // load-use on rs1
        tbl[3].i = mk(0, 0, 0, 1, 1, 1, 0, 0); tbl[3].e = O_IDLE;  // load to x0
        tbl[4].i = mk(7, 3, 7, 0, 1, 1, 0, 0); tbl[4].e = O_IDLE;  // rs1 matches but unused
        tbl[5].i = mk(5, 5, 5, 1, 1, 0, 0, 0); tbl[5].e = O_IDLE;  // match, not a load
        tbl[6].i = mk(1, 5, 5, 0, 1, 1, 0, 1); tbl[6].e = O_BR;    // branch suppresses load-use
        tbl[7].i = mk(0, 0, 0, 0, 0, 0, 1, 1); tbl[7].e = O_BR;    // branch drops multicycle
        tbl[8].i = idle;                       tbl[8].e = O_IDLE;  // no MC_BUSY entered

        reset = 1'b0;
        drive(idle);
        #2;
        do_reset();

        // Table vectors from RUN
        for (int k = 0; k < 9; k++) begin
            step(tbl[k].i);
            chk($sformatf("table_%0d", k), 32'(last_out), 32'(tbl[k].e));
        end

        // Single load-use stall: counter 0 -> 1, released next cycle
        do_reset();
        step(mk(0, 5, 5, 0, 1, 1, 0, 0));
        chk("lu_stall_count", 32'(stall_a), 32'd1);
        step(mk(0, 5, 6, 0, 1, 0, 0, 0));
        chk("lu_release_pc", 32'(last_out.pc), 32'd1);

        // Multi-cycle op profile
        do_reset();
        pc_low = 0; busy_n = 0; hold_n = 0; done_at = -1;
        for (int k = 0; k < 6; k++) begin
            step(k == 0 ? mk(0, 0, 0, 0, 0, 0, 1, 0) : idle);
            if (!last_out.pc)  pc_low++;
            if (last_out.busy) busy_n++;
            if (last_out.hold) hold_n++;
            if (last_out.done) done_at = k;
        end
        chk("mc_pc_low_cycles", 32'(pc_low), 32'd4);
        chk("mc_busy_cycles", 32'(busy_n), 32'd3);
        chk("mc_hold_cycles", 32'(hold_n), 32'd3);
        chk("mc_done_cycle", 32'(done_at), 32'd3);
        chk("mc_stall_count", 32'(stall_a), 32'd4);

        // Reset on the 2nd MC_BUSY cycle
        do_reset();
        step(mk(0, 0, 0, 0, 0, 0, 1, 0));
        step(idle);
        reset = 1'b0;
        busy_left = 0; cnt16 = 0; cnt4 = 0;
        #1;
        chk("mid_reset_outs", 32'(act_a), 32'(O_RESET));
        chk("mid_reset_stall", 32'(stall_a), 32'd0);
        @(posedge clk);
        #1;
        chk("mid_reset_done", 32'(done_a), 32'd0);
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        step(idle);
        chk("after_reset_pc", 32'(last_out.pc), 32'd1);
        chk("after_reset_busy", 32'(last_out.busy), 32'd0);

        // Back-to-back multicycle for 20 stall cycles: 4-bit counter saturates
        do_reset();
        for (int k = 0; k < 20; k++) step(mk(0, 0, 0, 0, 0, 0, 1, 0));
        chk("sat_cnt4", 32'(stall_b), 32'd15);
        chk("sat_cnt16", 32'(stall_a), 32'd20);

        // Randomized traffic against the model
        do_reset();
        for (int k = 0; k < 400; k++) begin
            v = mk($urandom_range(3), $urandom_range(3), $urandom_range(3),
                   1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
                   ($urandom_range(9) == 0), ($urandom_range(7) == 0));
            step(v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
